// File: rtl/gate_neuron_scheduler_pkg.sv
// Shared types and sizing helpers for the gate neuron scheduler and its result bank.
package gate_neuron_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_STORE = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    // Full-precision product plus one carry bit from the lane accumulator.
    function automatic int res_w(input int data_width);
        return 2 * data_width + 1;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Never returns 0 so that degenerate sizes still give a legal vector width.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/gate_neuron_scheduler_result_bank.sv
// Packed row store for one gate: each masked lane writes its result into row row_base+i.
module gate_result_bank
    import gate_neuron_scheduler_pkg::*;
#(
    parameter int RES_W      = 33,
    parameter int HIDDEN_OUT = 15,
    parameter int LANES      = 2,
    parameter int RB_W       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [RB_W-1:0]             row_base,
    input  logic [LANES-1:0]            lane_mask,
    input  logic [RES_W*LANES-1:0]      lane_result,
    output logic [RES_W*HIDDEN_OUT-1:0] final_vec
);

    // Per-row decode: a row takes the lane whose offset from row_base lands on it.
    always_ff @(posedge clk) begin
        if (rst) begin
            final_vec <= '0;
        end else if (we) begin
            for (int r = 0; r < HIDDEN_OUT; r++) begin
                for (int i = 0; i < LANES; i++) begin
                    if (lane_mask[i] && (int'(row_base) + i == r)) begin
                        final_vec[RES_W*r +: RES_W] <= lane_result[RES_W*i +: RES_W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/gate_neuron_scheduler.sv
// Time-multiplexes HIDDEN_OUT gate neurons onto LANES neuron lanes, one batch of rows at a time,
// advancing on the lanes' done flags with a per-batch watchdog.
module gate_neuron_scheduler
    import gate_neuron_scheduler_pkg::*;
#(
    parameter int  DATA_WIDTH = 16,
    parameter int  HIDDEN_OUT = 15,
    parameter int  LANES      = 2,
    parameter int  TIMEOUT    = 255,
    localparam int RES_W      = res_w(DATA_WIDTH),
    localparam int RB_W       = clog2_min1(HIDDEN_OUT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [RB_W-1:0]             row_base,
    output logic [LANES-1:0]            lane_mask,
    output logic                        lane_load,
    output logic                        neuron_en,
    input  logic [LANES-1:0]            neuron_done,
    input  logic [RES_W*LANES-1:0]      lane_result,
    output logic [RES_W*HIDDEN_OUT-1:0] final_vec,
    output logic [2:0]                  dbg_state
);

    localparam int NB      = ceil_div(HIDDEN_OUT, LANES);
    localparam int BATCH_W = clog2_min1(NB);
    localparam int WD_W    = 16;

    // Handshake: start is a level, accepted only in IDLE (ignored while busy, including FIN);
    // done is a single-cycle pulse in FIN with final_vec already holding the new rows.
    state_e              state;
    state_e              state_next;
    logic [BATCH_W-1:0]  batch;
    logic [WD_W-1:0]     wdog;
    logic [WD_W:0]       wdog_next;
    logic                all_done;
    logic                timeout_hit;
    logic                last_batch;
    logic                bank_we;

    assign dbg_state   = state;
    assign wdog_next   = {1'b0, wdog} + {{WD_W{1'b0}}, 1'b1};
    assign timeout_hit = (wdog_next == (WD_W+1)'(TIMEOUT));
    assign all_done    = ((neuron_done & lane_mask) == lane_mask);
    assign last_batch  = (batch == BATCH_W'(NB - 1));

    // Rows past HIDDEN_OUT in the final batch belong to no neuron.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i] = (int'(row_base) + i) < HIDDEN_OUT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_RUN;
            ST_RUN: begin
                // A done seen on the watchdog's last cycle still counts as success.
                if (all_done)         state_next = ST_STORE;
                else if (timeout_hit) state_next = ST_FIN;
            end
            ST_STORE: state_next = last_batch ? ST_FIN : ST_LOAD;
            ST_FIN:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        done      = (state == ST_FIN);
        lane_load = (state == ST_LOAD);
        neuron_en = (state == ST_RUN);
        bank_we   = (state == ST_STORE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            batch    <= '0;
            row_base <= '0;
            wdog     <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        batch    <= '0;
                        row_base <= '0;
                        wdog     <= '0;
                        err      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    wdog <= wdog_next[WD_W-1:0];
                    if (!all_done && timeout_hit) err <= 1'b1;
                end
                ST_STORE: begin
                    if (!last_batch) begin
                        batch    <= batch + BATCH_W'(1);
                        row_base <= row_base + RB_W'(LANES);
                        wdog     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    gate_result_bank #(
        .RES_W      (RES_W),
        .HIDDEN_OUT (HIDDEN_OUT),
        .LANES      (LANES),
        .RB_W       (RB_W)
    ) u_bank (
        .clk         (clk),
        .rst         (rst),
        .we          (bank_we),
        .row_base    (row_base),
        .lane_mask   (lane_mask),
        .lane_result (lane_result),
        .final_vec   (final_vec)
    );

endmodule
